// File: rtl/gear_shift_sequencer_if.sv
// gear_shift_sequencer_if: Avalon-MM slave bus bundle for the gear shift sequencer
// Signals: address[1:0], chipselect, write_n (active low), writedata[31:0] from master; readdata[31:0] from slave.
interface gear_shift_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gear_shift_sequencer.sv
// gear_shift_sequencer: Avalon-MM slave stepping gear_out one gear at a time toward a target with a programmable dwell
// Ports: clk, reset (async, active high), bus (Avalon-MM slave: a0 target/gear, a1 status, a2 dwell, a3 target),
//   gear_out (engaged gear), clutch_out (1 = disengaged), irq (shift complete).
// Optional: define GEAR_SEQ_IRQ_EN to enable irq_pend/irq; otherwise irq is tied 0 and irq_pend reads 0.
module gear_shift_sequencer #(
  parameter int GEAR_W    = 2,
  parameter int MAX_GEAR  = 3,
  parameter int DWELL_W   = 16,
  parameter int DWELL_RST = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  gear_shift_sequencer_if.slave bus,
  output logic [GEAR_W-1:0]     gear_out,
  output logic                  clutch_out,
  output logic                  irq
);
  typedef enum logic [1:0] {IDLE, DISENGAGE, SETTLE, ENGAGE} state_t;
  state_t state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell;
  logic [GEAR_W-1:0] target, tgt_n, gear_n, step;
  logic wr, tgt_ok, busy, error, irq_pend, done;
  assign wr = bus.chipselect & ~bus.write_n;
  assign tgt_ok = bus.writedata <= 32'(MAX_GEAR);
  // decisions use the target being written this cycle so sequencing starts right after the write
  assign tgt_n = wr && bus.address == 2'd0 && tgt_ok ? bus.writedata[GEAR_W-1:0] : target;
  assign step = tgt_n > gear_out ? gear_out + 1'b1 : gear_out - 1'b1;
  assign busy = state != IDLE;
  assign clutch_out = state == DISENGAGE || state == SETTLE;
  always_comb begin
    state_n = state;
    gear_n = gear_out;
    done = 1'b0;
    cnt_n = state == IDLE || cnt == '0 ? dwell - 1'b1 : cnt - 1'b1;
    if (state == IDLE)
      state_n = tgt_n != gear_out ? DISENGAGE : IDLE;
    else if (cnt == '0) begin
      done = state == ENGAGE;
      state_n = state == ENGAGE ? IDLE : tgt_n == gear_out ? ENGAGE : SETTLE;
      gear_n = state != ENGAGE && tgt_n != gear_out ? step : gear_out;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      gear_out <= '0;
      target <= '0;
      dwell <= DWELL_W'(DWELL_RST);
      error <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gear_out <= gear_n;
      target <= tgt_n;
      if (wr && bus.address == 2'd2)
        dwell <= bus.writedata[DWELL_W-1:0] == '0 ? DWELL_W'(1) : bus.writedata[DWELL_W-1:0];
      if (wr && bus.address == 2'd0 && !tgt_ok)
        error <= 1'b1;
      else if (wr && bus.address == 2'd1 && bus.writedata[1])
        error <= 1'b0;
    end
`ifdef GEAR_SEQ_IRQ_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)
      irq_pend <= 1'b0;
    else if (done)
      irq_pend <= 1'b1;
    else if (wr && bus.address == 2'd1 && bus.writedata[2])
      irq_pend <= 1'b0;
  assign irq = irq_pend;
`else
  assign irq_pend = 1'b0;
  assign irq = 1'b0;
`endif
  always_comb
    bus.readdata = bus.address == 2'd0 ? 32'(gear_out) :
                   bus.address == 2'd1 ? {29'd0, irq_pend, error, busy} :
                   bus.address == 2'd2 ? 32'(dwell) : 32'(target);
endmodule
